// File: rtl/den_win_buf_pkg.sv
// Shared constants, pixel type and window layout helper for the denoise window buffer.
package den_pkg;

    localparam int DEN_DATA_WIDTH = 16;
    localparam int DEN_WIN        = 5;
    localparam int DEN_MAX_COLS   = 256;
    localparam int DEN_ADDR_W     = 8;

    typedef logic [DEN_DATA_WIDTH-1:0] pixel_t;

    // Bit offset of window element (r,c); r=0 is the oldest row, c=0 the left column.
    function automatic int win_idx(input int r, input int c,
                                   input int win = DEN_WIN,
                                   input int dw  = DEN_DATA_WIDTH);
        return (r * win + c) * dw;
    endfunction

endpackage

// File: rtl/den_win_buf_if.sv
// Pixel-in / window-out handshake bundle; the buffer takes the slave side.
interface den_win_buf_if
    import den_pkg::*;
#(
    parameter int DATA_WIDTH = DEN_DATA_WIDTH,
    parameter int WIN        = DEN_WIN,
    parameter int ADDR_W     = DEN_ADDR_W
);

    logic [ADDR_W:0]                cfg_cols;
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_WIDTH-1:0]          in_data;
    logic                           in_sof;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH*WIN*WIN-1:0]  out_win;
    logic                           out_eol;

    modport master (
        output cfg_cols, in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_win, out_eol
    );

    modport slave (
        input  cfg_cols, in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_win, out_eol
    );

endinterface

// File: rtl/den_line_shift.sv
// Column-addressed chain of line memories: each write pushes the column one line deeper.
module den_line_shift #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int MAX_COLS   = 256,
    parameter int ADDR_W     = 8
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [DATA_WIDTH-1:0]            din,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0] taps
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_line
            logic [DATA_WIDTH-1:0] mem [MAX_COLS];

            // Taps are read before the write lands, so line k sees line k-1's old value.
            assign taps[gi] = mem[addr];

            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (we) begin
                        mem[addr] <= din;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (we) begin
                        mem[addr] <= taps[gi-1];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/den_win_buf.sv
// Raster-to-window buffer: emits one WIN x WIN window per accepted pixel once the
// window lies entirely inside the frame.
module den_win_buf
    import den_pkg::*;
#(
    parameter int DATA_WIDTH = DEN_DATA_WIDTH,
    parameter int WIN        = DEN_WIN,
    parameter int MAX_COLS   = DEN_MAX_COLS,
    parameter int ADDR_W     = DEN_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    den_win_buf_if.slave  bus
);

    localparam int ROW_W = $clog2(WIN);
    localparam int WBITS = DATA_WIDTH * WIN * WIN;

    logic [ADDR_W-1:0]  col_cnt_reg;
    logic [ROW_W-1:0]   row_cnt_reg;
    logic [ADDR_W:0]    cols_q_reg;
    logic               out_valid_reg;
    logic               out_eol_reg;
    logic [WBITS-1:0]   win_reg;
    logic [WBITS-1:0]   win_next;

    logic               accept;
    logic [ADDR_W-1:0]  cur_col;
    logic [ROW_W-1:0]   cur_row;
    logic [ADDR_W:0]    cur_cols;
    logic [ADDR_W:0]    cfg_clamped;
    logic               last_col;
    logic               win_hit;

    logic [WIN-2:0][DATA_WIDTH-1:0] tap_col;
    logic [WIN-1:0][DATA_WIDTH-1:0] new_col;

    assign bus.in_ready  = !out_valid_reg || bus.out_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_eol   = out_eol_reg;
    assign bus.out_win   = win_reg;

    assign accept = bus.in_valid && bus.in_ready;

    // A start-of-frame pixel is position (0,0) of a frame using the freshly sampled length.
    assign cfg_clamped = (bus.cfg_cols > (ADDR_W+1)'(MAX_COLS)) ? (ADDR_W+1)'(MAX_COLS)
                                                                : bus.cfg_cols;
    assign cur_col  = bus.in_sof ? '0 : col_cnt_reg;
    assign cur_row  = bus.in_sof ? '0 : row_cnt_reg;
    assign cur_cols = bus.in_sof ? cfg_clamped : cols_q_reg;

    assign last_col = ({1'b0, cur_col} == (cur_cols - (ADDR_W+1)'(1)));
    assign win_hit  = (cur_cols >= (ADDR_W+1)'(WIN))
                   && (cur_col >= ADDR_W'(WIN-1))
                   && (cur_row >= ROW_W'(WIN-1));

    den_line_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WIN-1),
        .MAX_COLS   (MAX_COLS),
        .ADDR_W     (ADDR_W)
    ) u_line_shift (
        .clk  (clk),
        .we   (accept),
        .addr (cur_col),
        .din  (bus.in_data),
        .taps (tap_col)
    );

    genvar gi;
    generate
        // Incoming column: bottom row is the live pixel, higher rows come from older lines.
        for (gi = 0; gi < WIN; gi++) begin : g_col
            if (gi == WIN-1) begin : g_bottom
                assign new_col[gi] = bus.in_data;
            end else begin : g_line
                assign new_col[gi] = tap_col[WIN-2-gi];
            end
        end

        for (gi = 0; gi < WIN*WIN; gi++) begin : g_win
            if ((gi % WIN) == WIN-1) begin : g_right
                assign win_next[win_idx(gi/WIN, gi%WIN, WIN, DATA_WIDTH) +: DATA_WIDTH] =
                    new_col[gi/WIN];
            end else begin : g_shift
                assign win_next[win_idx(gi/WIN, gi%WIN, WIN, DATA_WIDTH) +: DATA_WIDTH] =
                    win_reg[win_idx(gi/WIN, gi%WIN + 1, WIN, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            cols_q_reg    <= (ADDR_W+1)'(MAX_COLS);
            out_valid_reg <= 1'b0;
            out_eol_reg   <= 1'b0;
            win_reg       <= '0;
        end else if (accept) begin
            cols_q_reg  <= cur_cols;
            win_reg     <= win_next;
            col_cnt_reg <= last_col ? '0 : cur_col + ADDR_W'(1);
            // Row count saturates: once WIN-1 lines are buffered every row is window-capable.
            if (last_col && (cur_row != ROW_W'(WIN-1))) begin
                row_cnt_reg <= cur_row + ROW_W'(1);
            end else begin
                row_cnt_reg <= cur_row;
            end
            if (win_hit) begin
                out_valid_reg <= 1'b1;
                out_eol_reg   <= last_col;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_den_win_buf.sv
// Randomised bench for den_win_buf against a frame-store reference model.
module tb_den_win_buf;
    import den_pkg::*;

    localparam int DW   = 16;
    localparam int WIN  = 5;
    localparam int MAXC = 256;
    localparam int AW   = 8;
    localparam int WB   = DW * WIN * WIN;

    typedef struct {
        logic [WB-1:0] win;
        logic          eol;
    } exp_t;

    logic clk;
    logic rst_n;

    den_win_buf_if #(.DATA_WIDTH(DW), .WIN(WIN), .ADDR_W(AW)) bus ();

    den_win_buf #(
        .DATA_WIDTH (DW),
        .WIN        (WIN),
        .MAX_COLS   (MAXC),
        .ADDR_W     (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pixels of the current frame in arrival order.
    logic [DW-1:0] frame_q[$];
    int            m_cols = MAXC;
    exp_t          exp_q[$];

    int  cyc = 0;
    int  acc37_cyc = -1;
    int  first_cyc = -1;
    int  win_cnt = 0;
    int  eol_cnt = 0;
    int  hold_cnt = 0;
    logic [WB-1:0] first_win = '0;
    logic [WB-1:0] prev_win = '0;
    logic          prev_hold = 1'b0;

    int  stall_cnt = 0;
    bit  rand_ready = 0;
    bit  gap_mode = 1;

    task automatic model_accept(input logic [DW-1:0] d, input logic sof, input int cfg);
        exp_t e;
        int n, row, col;
        if (sof) begin
            frame_q.delete();
            m_cols = (cfg > MAXC) ? MAXC : cfg;
        end
        frame_q.push_back(d);
        if (frame_q.size() == 37) acc37_cyc = cyc;
        if (m_cols >= WIN) begin
            n   = frame_q.size() - 1;
            row = n / m_cols;
            col = n % m_cols;
            if (row >= WIN-1 && col >= WIN-1) begin
                e.win = '0;
                for (int r = 0; r < WIN; r++)
                    for (int c = 0; c < WIN; c++)
                        e.win[(r*WIN + c)*DW +: DW] =
                            frame_q[(row-WIN+1+r)*m_cols + (col-WIN+1+c)];
                e.eol = (col == m_cols - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Consumer back-pressure.
    always @(posedge clk) begin
        #2;
        if (stall_cnt > 0) begin
            bus.out_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: transfers happen on the next rising edge after what is seen here.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_window", WB'(1), WB'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("window", bus.out_win, e.win);
                check_eq("eol", WB'(bus.out_eol), WB'(e.eol));
            end
            $display("win %0d eol=%0b br=%h", win_cnt, bus.out_eol, bus.out_win[(WIN*WIN-1)*DW +: DW]);
            if (win_cnt == 0) begin
                first_win = bus.out_win;
                first_cyc = cyc;
            end
            win_cnt++;
            if (bus.out_eol) eol_cnt++;
        end
        if (bus.out_valid && !bus.out_ready) begin
            hold_cnt++;
            check_eq("stall_in_ready", WB'(bus.in_ready), WB'(0));
            if (prev_hold) check_eq("stall_win_stable", bus.out_win, prev_win);
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_win  = bus.out_win;
        if (bus.in_valid && bus.in_ready)
            model_accept(bus.in_data, bus.in_sof, int'(bus.cfg_cols));
    end

    task automatic send_pixel(input logic [DW-1:0] d, input logic sof, input int cfg);
        int t = 0;
        if (gap_mode) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.in_sof   = 1'($urandom_range(0, 1));
                bus.cfg_cols = 9'($urandom_range(0, 511));
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        bus.cfg_cols = sof ? 9'(cfg) : 9'($urandom_range(0, 511));
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            t++;
            if (t > 200) begin
                check_eq("accept_timeout", WB'(0), WB'(1));
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int cfg, input int rows, input bit pat,
                              input int n_limit, input int stall_at, input int stall_len);
        int cols;
        logic [DW-1:0] d;
        cols = (cfg > MAXC) ? MAXC : cfg;
        for (int i = 0; i < rows*cols && i < n_limit; i++) begin
            d = pat ? DW'((i/cols)*16 + (i%cols)) : DW'($urandom);
            send_pixel(d, i == 0, cfg);
            if (i == stall_at) stall_cnt = stall_len;
        end
    endtask

    task automatic drain();
        int t = 0;
        forever begin
            @(negedge clk);
            if (!bus.out_valid && exp_q.size() == 0) break;
            t++;
            if (t > 200) begin
                check_eq("drain_timeout", WB'(exp_q.size()), WB'(0));
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic start_frame();
        win_cnt  = 0;
        eol_cnt  = 0;
        hold_cnt = 0;
        first_cyc = -1;
        acc37_cyc = -1;
    endtask

    task automatic check_ref_frame(input string tag);
        check_eq({tag, "_windows"}, WB'(win_cnt), WB'(16));
        check_eq({tag, "_eol_count"}, WB'(eol_cnt), WB'(4));
        check_eq({tag, "_first_00"}, WB'(first_win[0 +: DW]), WB'(16'h00));
        check_eq({tag, "_first_44"}, WB'(first_win[(4*WIN+4)*DW +: DW]), WB'(16'h44));
        check_eq({tag, "_leftover"}, WB'(exp_q.size()), WB'(0));
    endtask

    initial begin
        int rc, rr;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.cfg_cols  = 9'd4;
        bus.out_ready = 1'b1;
        #1;
        check_eq("rst_out_valid", WB'(bus.out_valid), WB'(0));
        check_eq("rst_out_win", bus.out_win, WB'(0));
        check_eq("rst_out_eol", WB'(bus.out_eol), WB'(0));
        check_eq("rst_in_ready", WB'(bus.in_ready), WB'(1));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reference 8x8 frame; cfg_cols wanders off 8 after the sof pixel.
        start_frame();
        send_frame(8, 8, 1, 1 << 30, -1, 0);
        drain();
        check_ref_frame("s2");
        check_eq("s2_latency", WB'(first_cyc - acc37_cyc), WB'(1));

        // Same frame with a 10-cycle consumer stall right after pixel 0x45.
        start_frame();
        send_frame(8, 8, 1, 1 << 30, 37, 10);
        drain();
        check_ref_frame("s3");
        check_eq("s3_hold_cycles", WB'(hold_cnt), WB'(10));

        // Truncated frame followed by a fresh in_sof frame.
        start_frame();
        send_frame(8, 8, 1, 20, -1, 0);
        send_frame(8, 8, 1, 1 << 30, -1, 0);
        drain();
        check_ref_frame("s4");

        // Line shorter than the window.
        start_frame();
        send_frame(4, 8, 1, 1 << 30, -1, 0);
        drain();
        check_eq("s5_short_windows", WB'(win_cnt), WB'(0));

        // Over-long line clamps to MAX_COLS.
        start_frame();
        send_frame(300, 5, 0, 1 << 30, -1, 0);
        drain();
        check_eq("s5_long_windows", WB'(win_cnt), WB'(252));
        check_eq("s5_long_eol", WB'(eol_cnt), WB'(1));

        // Asynchronous reset with a window pending.
        start_frame();
        send_frame(8, 8, 1, 38, 37, 20);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check_eq("s6_pre_valid", WB'(bus.out_valid), WB'(1));
        rst_n = 1'b0;
        #1;
        check_eq("s6_async_valid", WB'(bus.out_valid), WB'(0));
        check_eq("s6_async_win", bus.out_win, WB'(0));
        exp_q.delete();
        frame_q.delete();
        m_cols    = MAXC;
        stall_cnt = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_frame();
        send_frame(8, 8, 1, 1 << 30, -1, 0);
        drain();
        check_ref_frame("s6");

        // Random line lengths, random data, random back-pressure.
        rand_ready = 1;
        for (int k = 0; k < 4; k++) begin
            rc = $urandom_range(5, 20);
            rr = $urandom_range(5, 8);
            start_frame();
            send_frame(rc, rr, 0, 1 << 30, -1, 0);
            drain();
            check_eq("rand_windows", WB'(win_cnt), WB'((rr-WIN+1)*(rc-WIN+1)));
            check_eq("rand_eol", WB'(eol_cnt), WB'(rr-WIN+1));
        end
        rand_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
